dm_arbiter: RTL
===============

Name: dm_arbiter

Overview:
- Shares the single-port data memory (dm) between two requesters.
  - Requester 0: CPU data port, driven from the MEM state of the multicycle controller.
  - Requester 1: DMA/program-loader port.
- Sits between those requesters and dm. The CPU controller holds its MEM state until m0_ack.
- Word accesses only; byte handling stays in bitsaver, upstream of port 0.

Parameters:
- PRIO_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority to m0 with starvation guard.
- STARVE_LIMIT, 4, in PRIO_MODE 1, the number of consecutive lost arbitrations after which m1 is force-granted (range 1..15).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- m0_req  in  1  CPU access request, level, held until m0_ack
- m0_we  in  1  CPU write enable (1 = write)
- m0_addr  in  10  CPU word address (byte addr[11:2])
- m0_wdata  in  32  CPU write data
- m0_ack  out  1  one-cycle completion pulse to CPU
- m1_req  in  1  DMA access request, level, held until m1_ack
- m1_we  in  1  DMA write enable
- m1_addr  in  10  DMA word address
- m1_wdata  in  32  DMA write data
- m1_ack  out  1  one-cycle completion pulse to DMA
- rdata  out  32  registered read data, valid in the ack cycle
- mem_addr  out  10  to dm address
- mem_din  out  32  to dm write data
- mem_we  out  1  to dm write enable
- mem_dout  in  32  from dm, combinational read
- busy  out  1  1 when state != IDLE
- owner  out  1  current/last granted requester

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE, owner=0, rdata=0, m0_ack=m1_ack=0, starve_cnt=0.
  - rr_last=1, so m0 wins the first round-robin tie.
- mem_we is forced 0 in any cycle with rst=1.
- State machine: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - If no req, stay in IDLE.
  - Otherwise, latch winner into owner; latch addr/we/wdata of winner into internal regs; go to ACCESS.
- Arbitration, PRIO_MODE 0:
  - Single req wins.
  - If both req, grant the requester != rr_last.
  - rr_last updates to owner on entering ACCESS.
- Arbitration, PRIO_MODE 1:
  - m0 wins ties unless starve_cnt == STARVE_LIMIT, in which case m1 wins.
  - starve_cnt increments (saturating) each time m1 requests and loses.
  - starve_cnt clears when m1 is granted.
- ACCESS (1 cycle):
  - mem_addr and mem_din come from the latched regs; mem_we = latched we.
  - dm write commits at the clk edge ending ACCESS.
  - rdata <= mem_dout at that edge, for reads and writes alike (write returns the old word).
  - Next state RESP.
- RESP (1 cycle):
  - Ack of owner = 1, the other ack = 0; rdata stable. Next state IDLE.
- Outside ACCESS: mem_we=0, and mem_addr/mem_din hold the latched values (no X toggling).
- Latency: req seen in IDLE at edge T -> ACCESS in cycle T+1 -> ack in cycle T+2.
  - Ack is never combinational from req.
  - Peak throughput: one access per 3 cycles.
- Request rules:
  - Requester must hold req/we/addr/wdata stable until its ack.
  - Request signals are sampled only on the IDLE->ACCESS edge.
  - Changes after that edge are ignored; the latched transaction completes and acks even if req drops.
- Req still high in the cycle after ack (IDLE) is a new request. Back-to-back requests from the same master are legal.
- Simultaneous events:
  - Both req in IDLE: exactly one granted per policy.
  - The loser keeps req high and is served in the next IDLE.
  - In PRIO_MODE 0 the loser is guaranteed the next grant.
- Reset mid-operation:
  - rst in ACCESS: no write commits (mem_we gated).
  - rst in ACCESS or RESP: no ack issued; state returns to IDLE; the requester retries after reset.
- m0_ack and m1_ack are never both 1; at most one ack per transaction.
- busy=1 in ACCESS and RESP.

Test Plan:
- m0 write addr=10'h004 data=32'hDEADBEEF, then m0 read addr=10'h004 -> mem_we high only in the write's ACCESS cycle. The read's m0_ack comes 2 cycles after req, with rdata=32'hDEADBEEF.
- PRIO_MODE 0: m0 and m1 both request continuously (reads) -> grants alternate 0,1,0,1 starting with m0. Each ack is a 1-cycle pulse; the two acks never overlap.
- PRIO_MODE 1, STARVE_LIMIT=4: both request continuously -> m0 is granted 4 times, then m1 once, then the pattern repeats; starve_cnt returns to 0 after the m1 grant.
- m1 write addr=10'h3FF data=32'h12345678; drop m1_req and change m1_wdata during ACCESS -> 32'h12345678 is written at 10'h3FF and m1_ack still pulses.
- Assert rst during the ACCESS cycle of an m0 write to addr=10'h010 -> the memory word is unchanged, no m0_ack, state=IDLE, and rdata=0 after the reset edge.
- Idle bus, no requests for 10 cycles -> busy=0, mem_we=0, both acks 0. A single m1 read then completes with m1_ack at exactly T+2.

Source files
------------

// File: rtl/dm_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the dm array.
// The arbiter takes the slave view; the requester/memory environment takes the master view.
interface dm_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [9:0]  m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_ack;
  logic        m1_req;
  logic        m1_we;
  logic [9:0]  m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_ack;
  logic [31:0] rdata;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din;
  logic        mem_we;
  logic [31:0] mem_dout;
  logic        busy;
  logic        owner;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_dout,
    output m0_ack, m1_ack, rdata,
    output mem_addr, mem_din, mem_we,
    output busy, owner
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_dout,
    input  m0_ack, m1_ack, rdata,
    input  mem_addr, mem_din, mem_we,
    input  busy, owner
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-requester arbiter for the single-port data memory: CPU (m0) and DMA/loader (m1).
// Each granted word access runs IDLE -> ACCESS -> RESP and acks the owner in RESP.
module dm_arbiter #(
  parameter int unsigned PRIO_MODE    = 0,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic         clk,
  input logic         rst,
  dm_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);
  localparam bit         FIXED_PRIO = (PRIO_MODE != 32'd0);

  state_e      state_q,   state_d;
  logic        owner_q,   owner_d;
  logic        rr_last_q, rr_last_d;
  logic [3:0]  starve_q,  starve_d;
  logic [9:0]  addr_q,    addr_d;
  logic [31:0] wdata_q,   wdata_d;
  logic [31:0] rdata_q,   rdata_d;
  logic        mem_we_q,  mem_we_d;
  logic        ack0_q,    ack0_d;
  logic        ack1_q,    ack1_d;
  logic        busy_q,    busy_d;
  logic        grant_s;
  logic        any_req_s;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    if (v == 4'hF) begin
      return v;
    end else begin
      return v + 4'd1;
    end
  endfunction

  // Winner selection; only consulted in IDLE.
  always_comb begin
    any_req_s = bus.m0_req | bus.m1_req;
    grant_s   = 1'b0;
    if (bus.m0_req && bus.m1_req) begin
      if (FIXED_PRIO) begin
        grant_s = (starve_q == LIMIT);
      end else begin
        grant_s = ~rr_last_q;
      end
    end else begin
      grant_s = bus.m1_req;
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    starve_d  = starve_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    busy_d    = busy_q;
    mem_we_d  = 1'b0;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          state_d   = ACCESS;
          owner_d   = grant_s;
          rr_last_d = grant_s;
          busy_d    = 1'b1;
          if (grant_s) begin
            addr_d   = bus.m1_addr;
            wdata_d  = bus.m1_wdata;
            mem_we_d = bus.m1_we;
          end else begin
            addr_d   = bus.m0_addr;
            wdata_d  = bus.m0_wdata;
            mem_we_d = bus.m0_we;
          end
          // m1 can only lose while m0 also requests, so this counts real losses.
          if (FIXED_PRIO && grant_s) begin
            starve_d = 4'd0;
          end else if (FIXED_PRIO && bus.m1_req) begin
            starve_d = sat_inc(starve_q);
          end else begin
            starve_d = starve_q;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      ACCESS: begin
        state_d = RESP;
        rdata_d = bus.mem_dout;
        ack0_d  = ~owner_q;
        ack1_d  = owner_q;
        busy_d  = 1'b1;
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      starve_q  <= 4'd0;
      addr_q    <= 10'd0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
      mem_we_q  <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      starve_q  <= starve_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      mem_we_q  <= mem_we_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      busy_q    <= busy_d;
    end
  end

  // Reset in flight must neither commit a write nor complete a handshake.
  assign bus.mem_we   = mem_we_q & ~rst;
  assign bus.m0_ack   = ack0_q & ~rst;
  assign bus.m1_ack   = ack1_q & ~rst;
  assign bus.mem_addr = addr_q;
  assign bus.mem_din  = wdata_q;
  assign bus.rdata    = rdata_q;
  assign bus.busy     = busy_q;
  assign bus.owner    = owner_q;

endmodule
